serial_adder: RTL and testbench

- Parametrised multi-cycle adder built from full-adder digit slices.
- Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, LSB digit first.
- Start/busy/done handshake lets arithmetic datapaths trade area for latency.
- Successor to the single-bit full adder: generalised width, digit size, registered carry, result holding.

---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/serial_adder_digit_adder.sv | 24 ++
 rtl/serial_adder.sv | 102 ++++++++++
 tb/tb_serial_adder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM encoding, default sizes
// and the step-counter width helper.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DIGIT = 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // clog2 of the step count, never narrower than one bit
    function automatic int cnt_width(input int steps);
        return (steps <= 2) ? 1 : $clog2(steps);
    endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// Combinational DIGIT-bit ripple of full adders; one digit slice per clock
// of the serial adder.
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout
);

    always_comb begin
        logic c;
        sum = '0;
        c   = cin;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
        end
        cout = c;
    end

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: adds a+b+cin DIGIT bits per clock, LSB digit first,
// with a start/busy/done handshake and a result held between completions.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIGIT = DEFAULT_DIGIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = cnt_width(STEPS);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    if ((WIDTH < 2) || (DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
        $error("serial_adder: DIGIT must be in 1..WIDTH and divide WIDTH");
    end

    state_e            state_q;
    logic [WIDTH-1:0]  a_q, b_q, psum_q, sum_q;
    logic [CW-1:0]     cnt_q;
    logic              carry_q, busy_q, done_q, cout_q;

    logic [DIGIT-1:0]  dsum;
    logic              carry_d;
    logic [WIDTH-1:0]  psum_d;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a    (a_q[DIGIT-1:0]),
        .b    (b_q[DIGIT-1:0]),
        .cin  (carry_q),
        .sum  (dsum),
        .cout (carry_d)
    );

    // New digit enters at the top so the LSB digit ends up at bit 0 after STEPS shifts
    always_comb begin
        psum_d = (psum_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            psum_q  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        psum_q  <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    carry_q <= carry_d;
                    psum_q  <= psum_d;
                    if (cnt_q == LAST) begin
                        sum_q   <= psum_d;
                        cout_q  <= carry_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder across several WIDTH/DIGIT configurations.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instances: 0: W8 D1, 1: W8 D4, 2: W4 D1, 3: W4 D2, 4: W4 D4
    logic [4:0] start_r = '0;
    logic [4:0] cin_r   = '0;
    logic [7:0] a_r [5];
    logic [7:0] b_r [5];
    logic [4:0] busy_w, done_w, cout_w;
    logic [7:0] s80, s81;
    logic [3:0] s42, s43, s44;

    logic [7:0] last_sum  [5];
    logic       last_cout [5];

    int vecs = 0;
    int miss = 0;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
        .clk(clk), .rst(rst), .start(start_r[0]), .a(a_r[0]), .b(b_r[0]), .cin(cin_r[0]),
        .busy(busy_w[0]), .done(done_w[0]), .sum(s80), .cout(cout_w[0]));
    serial_adder #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
        .clk(clk), .rst(rst), .start(start_r[1]), .a(a_r[1]), .b(b_r[1]), .cin(cin_r[1]),
        .busy(busy_w[1]), .done(done_w[1]), .sum(s81), .cout(cout_w[1]));
    serial_adder #(.WIDTH(4), .DIGIT(1)) u_w4d1 (
        .clk(clk), .rst(rst), .start(start_r[2]), .a(a_r[2][3:0]), .b(b_r[2][3:0]), .cin(cin_r[2]),
        .busy(busy_w[2]), .done(done_w[2]), .sum(s42), .cout(cout_w[2]));
    serial_adder #(.WIDTH(4), .DIGIT(2)) u_w4d2 (
        .clk(clk), .rst(rst), .start(start_r[3]), .a(a_r[3][3:0]), .b(b_r[3][3:0]), .cin(cin_r[3]),
        .busy(busy_w[3]), .done(done_w[3]), .sum(s43), .cout(cout_w[3]));
    serial_adder #(.WIDTH(4), .DIGIT(4)) u_w4d4 (
        .clk(clk), .rst(rst), .start(start_r[4]), .a(a_r[4][3:0]), .b(b_r[4][3:0]), .cin(cin_r[4]),
        .busy(busy_w[4]), .done(done_w[4]), .sum(s44), .cout(cout_w[4]));

    function automatic int steps_of(input int k);
        case (k)
            0: return 8;
            1: return 2;
            2: return 4;
            3: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic [7:0] get_sum(input int k);
        case (k)
            0: return s80;
            1: return s81;
            2: return {4'h0, s42};
            3: return {4'h0, s43};
            default: return {4'h0, s44};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Called just after the accept edge; walks STEPS edges checking busy/hold, then the result
    task automatic wait_done(input int k, input logic [7:0] es, input logic ec, input string nm);
        int bad = 0;
        int n = steps_of(k);
        for (int i = 1; i <= n; i++) begin
            @(posedge clk); #1;
            if (i < n) begin
                if (busy_w[k] !== 1'b1 || done_w[k] !== 1'b0 ||
                    get_sum(k) !== last_sum[k] || cout_w[k] !== last_cout[k])
                    bad++;
            end
        end
        chk({nm, " busy/hold cycles"}, bad, 0);
        chk({nm, " busy,done"}, {30'd0, busy_w[k], done_w[k]}, 32'b01);
        chk({nm, " cout,sum"}, {23'd0, cout_w[k], get_sum(k)}, {23'd0, ec, es});
        last_sum[k]  = es;
        last_cout[k] = ec;
    endtask

    task automatic run_op(input int k, input logic [7:0] av, input logic [7:0] bv,
                          input logic cv, input logic [7:0] es, input logic ec, input string nm);
        @(negedge clk);
        start_r[k] = 1'b1; a_r[k] = av; b_r[k] = bv; cin_r[k] = cv;
        @(posedge clk); #1;
        start_r[k] = 1'b0; a_r[k] = ~av; b_r[k] = ~bv; cin_r[k] = ~cv;
        wait_done(k, es, ec, nm);
        @(posedge clk); #1;
        chk({nm, " done after pulse"}, {31'd0, done_w[k]}, 0);
    endtask

    typedef struct {
        int         k;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 5; k++) begin
            a_r[k] = '0; b_r[k] = '0; last_sum[k] = '0; last_cout[k] = 1'b0;
        end

        tbl.push_back('{0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1});
        tbl.push_back('{0, 8'h55, 8'hAA, 1'b1, 8'h00, 1'b1});
        tbl.push_back('{0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0});
        tbl.push_back('{0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1});
        tbl.push_back('{0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0});
        tbl.push_back('{1, 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0});
        tbl.push_back('{1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1});
        tbl.push_back('{1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0});
        tbl.push_back('{2, 8'h0F, 8'h00, 1'b1, 8'h00, 1'b1});

        #1;
        for (int k = 0; k < 5; k++)
            chk($sformatf("reset inst%0d", k),
                {22'd0, busy_w[k], done_w[k], get_sum(k)}, 0);
        chk("reset couts", {27'd0, cout_w}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i])
            run_op(tbl[i].k, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].co,
                   $sformatf("tbl%0d", i));

        // start held high, operands changed mid-run, second op accepted in the done cycle
        @(negedge clk);
        start_r[0] = 1'b1; a_r[0] = 8'h10; b_r[0] = 8'h01; cin_r[0] = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        a_r[0] = 8'hFF; b_r[0] = 8'hFF;
        wait_done(0, 8'h11, 1'b0, "held-start op1");
        @(posedge clk); #1;
        chk("held-start reaccept busy,done", {30'd0, busy_w[0], done_w[0]}, 32'b10);
        @(negedge clk);
        start_r[0] = 1'b0;
        wait_done(0, 8'hFE, 1'b1, "held-start op2");

        // asynchronous reset three steps into an operation
        @(negedge clk);
        start_r[0] = 1'b1; a_r[0] = 8'h0F; b_r[0] = 8'h0F; cin_r[0] = 1'b0;
        @(posedge clk); #1;
        start_r[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrun reset outputs", {21'd0, busy_w[0], done_w[0], cout_w[0], get_sum(0)}, 0);
        for (int k = 0; k < 5; k++) begin
            last_sum[k] = '0; last_cout[k] = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;
        begin
            int dn = 0;
            repeat (10) begin
                @(posedge clk); #1;
                if (done_w[0] !== 1'b0 || busy_w[0] !== 1'b0) dn++;
            end
            chk("no done after reset", dn, 0);
        end
        run_op(0, 8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, "post-reset op");

        // exhaustive 4-bit operands for each digit size
        for (int k = 2; k < 5; k++)
            for (int av = 0; av < 16; av++)
                for (int bv = 0; bv < 16; bv++)
                    for (int cv = 0; cv < 2; cv++) begin
                        logic [4:0] t;
                        t = 5'(av) + 5'(bv) + 5'(cv);
                        run_op(k, 8'(av), 8'(bv), cv[0], {4'h0, t[3:0]}, t[4],
                               $sformatf("ex k%0d %0h+%0h+%0d", k, av, bv, cv));
                    end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
